if_id_stage: RTL
================

// Module: if_id_stage
// PURPOSE
//  IF/ID pipeline register plus load-use hazard control for the 5-stage RISC core.
//  Sits directly downstream of instruction fetch: captures PC and instruction each enabled cycle, presents them to decode.
//  Detects load-use hazards against the ID/EX instruction and drives fetch's stall input; squashes the fetched slot on jump.
//  Keeps saturating stall/flush/issue counters for performance debug.
// PARAMETERS
//  DATA_W     32            width of PC and instruction
//  NOP_INSTR  32'h0000_0000 encoding injected on flush/bubble
//  CNT_W      16            width of each performance counter
// PORTS
//  clk          in   1       core clock, rising edge
//  reset        in   1       synchronous, active-high
//  if_pc        in   DATA_W  PC of fetched instruction (fetch PC_out)
//  if_instr     in   DATA_W  fetched instruction (fetch Instruction_Code)
//  jump         in   1       taken jump/branch resolved this cycle; squash fetched slot
//  ext_stall    in   1       external hold (e.g. data memory busy); freezes this stage
//  ex_mem_read  in   1       instruction in ID/EX is a load
//  ex_rd        in   5       destination register of ID/EX instruction
//  ex_valid     in   1       ID/EX holds a real instruction
//  id_pc        out  DATA_W  registered PC to decode
//  id_instr     out  DATA_W  registered instruction to decode
//  id_valid     out  1       id_instr is a real instruction (0 = bubble)
//  stall        out  1       to fetch stall input; holds PC and instruction memory
//  id_ex_bubble out  1       decode must write a NOP into ID/EX this cycle
//  stall_cnt    out  CNT_W   cycles stalled by load-use hazard (saturating)
//  flush_cnt    out  CNT_W   slots squashed by jump (saturating)
//  issue_cnt    out  CNT_W   valid instructions passed to decode (saturating)
// BEHAVIOUR
//  Reset (sync, priority over all): id_pc=0, id_instr=NOP_INSTR, id_valid=0, state=RUN, all counters=0.
//   Combinational outputs (stall, id_ex_bubble) follow: both 0 after reset. Reset mid-stall returns to RUN next edge.
//  Fields: rs=id_instr[25:21], rt=id_instr[20:16]; rt compared only when opcode id_instr[31:26]==6'b000000 (R-type) or a store (opcode[31:29]==3'b101).
//  hazard = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==rs | (uses_rt & ex_rd==rt)).
//  FSM states:
//   RUN   : hazard & ~jump -> stall=1, id_ex_bubble=1, IF/ID holds, stall_cnt++, next HOLD.
//           jump -> IF/ID loads NOP_INSTR, id_valid=0, id_pc=if_pc, flush_cnt++, stay RUN.
//           else -> IF/ID loads if_pc/if_instr, id_valid=1, issue_cnt++.
//   HOLD  : stall=0, id_ex_bubble=0; load has advanced, IF/ID loads normally (or flushes if jump); next RUN.
//           Load-use stall is exactly one cycle; a second hazard is re-evaluated in RUN.
//  Priority per edge: reset > ext_stall > jump > hazard > normal load.
//  ext_stall=1: all registers, state and counters frozen; stall output forced 1; id_ex_bubble 0.
//  jump during hazard: jump wins; no bubble, no stall, flush_cnt++ only.
//  Latency: if_instr valid at edge N appears on id_instr after edge N (1 cycle).
//  Counters saturate at all-ones; no wrap. Counters do not count during ext_stall.
//  stall asserted same cycle as hazard (combinational from registered id_instr and ex_* inputs); no comb path from if_* to stall.
// TESTING
//  1 Reset: hold reset 2 cycles -> id_instr=NOP_INSTR, id_valid=0, stall=0, counters 0; release, next edge id_valid=1.
//  2 Straight-line: feed PCs 0,4,8 with distinct instrs -> each appears on id_* one edge later; issue_cnt=3.
//  3 Load-use: ex_mem_read=1, ex_rd=5, id_instr rs=5 -> stall=1, id_ex_bubble=1 one cycle, id_instr held, stall_cnt=1; then resumes.
//  4 No false hazard: ex_rd=0, or rt match on I-type non-store -> stall=0; issue continues.
//  5 Jump: jump=1 with if_instr=32'h1234_5678 -> id_instr=NOP_INSTR, id_valid=0, flush_cnt=1; jump+hazard same cycle -> no stall.
//  6 ext_stall 3 cycles mid-stream -> outputs/counters frozen, stall=1; saturation: preload near max, stall_cnt stops at all-ones.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Fetch/hazard inputs and decode/perf outputs of the IF/ID stage.
// The stage itself takes the slave side; whoever drives fetch and ID/EX takes the master side.
interface if_id_stage_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic [DATA_W-1:0] if_pc;
   logic [DATA_W-1:0] if_instr;
   logic              jump;
   logic              ext_stall;
   logic              ex_mem_read;
   logic [4:0]        ex_rd;
   logic              ex_valid;
   logic [DATA_W-1:0] id_pc;
   logic [DATA_W-1:0] id_instr;
   logic              id_valid;
   logic              stall;
   logic              id_ex_bubble;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   logic [CNT_W-1:0]  issue_cnt;

   modport master (
      output if_pc, if_instr, jump, ext_stall, ex_mem_read, ex_rd, ex_valid,
      input  id_pc, id_instr, id_valid, stall, id_ex_bubble,
             stall_cnt, flush_cnt, issue_cnt
   );

   modport slave (
      input  if_pc, if_instr, jump, ext_stall, ex_mem_read, ex_rd, ex_valid,
      output id_pc, id_instr, id_valid, stall, id_ex_bubble,
             stall_cnt, flush_cnt, issue_cnt
   );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, jump squash and
// saturating stall/flush/issue counters for performance debug.
module if_id_stage #(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000,
   parameter int                CNT_W     = 16
) (
   input  logic          clk,
   input  logic          reset,
   if_id_stage_if.slave  bus
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] id_pc_q, id_pc_d;
   logic [DATA_W-1:0] id_instr_q, id_instr_d;
   logic              id_valid_q, id_valid_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;

   logic [5:0] opcode;
   logic [4:0] rs, rt;
   logic       uses_rt;
   logic       hazard;
   logic       stall;
   logic       bubble;

   // Hazard looks only at registered id_instr and ex_* so fetch never sees a comb path from if_*.
   always_comb begin
      opcode  = id_instr_q[31:26];
      rs      = id_instr_q[25:21];
      rt      = id_instr_q[20:16];
      uses_rt = (opcode == 6'b000000) || (opcode[5:3] == 3'b101);
      hazard  = id_valid_q && bus.ex_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                ((bus.ex_rd == rs) || (uses_rt && (bus.ex_rd == rt)));
   end

   always_comb begin
      state_d     = state_q;
      id_pc_d     = id_pc_q;
      id_instr_d  = id_instr_q;
      id_valid_d  = id_valid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      issue_cnt_d = issue_cnt_q;
      stall       = 1'b0;
      bubble      = 1'b0;
      if (bus.ext_stall) begin
         stall = 1'b1;
      end else if (bus.jump) begin
         id_pc_d     = bus.if_pc;
         id_instr_d  = NOP_INSTR;
         id_valid_d  = 1'b0;
         flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + 1'b1;
         state_d     = ST_RUN;
      end else if ((state_q == ST_RUN) && hazard) begin
         // One bubble is enough: by the next cycle the load has produced its data.
         stall       = 1'b1;
         bubble      = 1'b1;
         stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;
         state_d     = ST_HOLD;
      end else begin
         id_pc_d     = bus.if_pc;
         id_instr_d  = bus.if_instr;
         id_valid_d  = 1'b1;
         issue_cnt_d = (issue_cnt_q == '1) ? issue_cnt_q : issue_cnt_q + 1'b1;
         state_d     = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         id_pc_q     <= '0;
         id_instr_q  <= NOP_INSTR;
         id_valid_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         issue_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         id_pc_q     <= id_pc_d;
         id_instr_q  <= id_instr_d;
         id_valid_q  <= id_valid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   assign bus.id_pc        = id_pc_q;
   assign bus.id_instr     = id_instr_q;
   assign bus.id_valid     = id_valid_q;
   assign bus.stall        = stall;
   assign bus.id_ex_bubble = bubble;
   assign bus.stall_cnt    = stall_cnt_q;
   assign bus.flush_cnt    = flush_cnt_q;
   assign bus.issue_cnt    = issue_cnt_q;

endmodule
